// File: rtl/riscv_core_ldalign.sv
// Load-alignment stage: turns a byte-addressed load into one or two aligned
// doubleword cache reads, merges the beats and right-justifies the result.
module riscv_core_ldalign #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned ADDR_W = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ldalign_req_valid,
    output logic              o_ldalign_req_ready,
    input  logic [ADDR_W-1:0] i_ldalign_addr,
    input  logic [1:0]        i_ldalign_r_w_size,
    input  logic              i_ldalign_su_extend,
    input  logic              i_ldalign_flush,
    output logic              o_ldalign_mem_valid,
    input  logic              i_ldalign_mem_ready,
    output logic [ADDR_W-1:0] o_ldalign_mem_addr,
    input  logic              i_ldalign_mem_rvalid,
    input  logic [XLEN-1:0]   i_ldalign_mem_rdata,
    output logic              o_ldalign_rsp_valid,
    input  logic              i_ldalign_rsp_ready,
    output logic [XLEN-1:0]   o_ldalign_rdata,
    output logic [1:0]        o_ldalign_r_w_size,
    output logic              o_ldalign_su_extend,
    output logic              o_ldalign_split
);

    localparam int unsigned SH_W = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
        S_REQ1,
        S_WAIT1,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          size_q;
    logic                su_q;
    logic                split_q;
    logic [XLEN-1:0]     beat0_q;
    logic [XLEN-1:0]     beat1_q;

    logic [3:0]          nbytes_in;
    logic                split_in;
    logic [ADDR_W-1:0]   addr0;
    logic [ADDR_W-1:0]   addr1;
    logic [5:0]          sh0;
    logic [SH_W-1:0]     sh1;
    logic [XLEN-1:0]     raw;
    logic [XLEN-1:0]     mask;
    logic [XLEN-1:0]     merged;

    // Split detection on the incoming request and the two beat addresses.
    always_comb begin
        nbytes_in = 4'(1) << i_ldalign_r_w_size;
        split_in  = (4'(i_ldalign_addr[2:0]) + nbytes_in) > 4'd8;
        addr0     = {addr_q[ADDR_W-1:3], 3'b000};
        addr1     = addr0 + ADDR_W'(8);
    end

    // Merge the beats, right-justify and zero the bytes above the access size.
    always_comb begin
        sh0  = {addr_q[2:0], 3'b000};
        sh1  = SH_W'(XLEN) - {1'b0, sh0};
        raw  = beat0_q >> sh0;
        mask = {XLEN{1'b1}};
        if (split_q) begin
            raw = raw | (beat1_q << sh1);
        end
        case (size_q)
            2'b00:   mask = XLEN'(8'hFF);
            2'b01:   mask = XLEN'(16'hFFFF);
            2'b10:   mask = XLEN'(32'hFFFF_FFFF);
            default: mask = {XLEN{1'b1}};
        endcase
        merged = raw & mask;
    end

    // Control FSM with registered outputs; flush outranks every other transition.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q             <= S_IDLE;
            addr_q              <= '0;
            size_q              <= '0;
            su_q                <= 1'b0;
            split_q             <= 1'b0;
            beat0_q             <= '0;
            beat1_q             <= '0;
            o_ldalign_req_ready <= 1'b1;
            o_ldalign_mem_valid <= 1'b0;
            o_ldalign_mem_addr  <= '0;
            o_ldalign_rsp_valid <= 1'b0;
            o_ldalign_rdata     <= '0;
            o_ldalign_r_w_size  <= '0;
            o_ldalign_su_extend <= 1'b0;
            o_ldalign_split     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_ldalign_req_valid && o_ldalign_req_ready) begin
                        addr_q              <= i_ldalign_addr;
                        size_q              <= i_ldalign_r_w_size;
                        su_q                <= i_ldalign_su_extend;
                        split_q             <= split_in;
                        o_ldalign_req_ready <= 1'b0;
                        o_ldalign_mem_valid <= 1'b1;
                        o_ldalign_mem_addr  <= {i_ldalign_addr[ADDR_W-1:3], 3'b000};
                        state_q             <= S_REQ0;
                    end
                end
                S_REQ0, S_REQ1: begin
                    if (i_ldalign_flush) begin
                        // An accepted read must still be drained before going idle.
                        o_ldalign_mem_valid <= 1'b0;
                        if (i_ldalign_mem_ready) begin
                            state_q <= S_DRAIN;
                        end else begin
                            o_ldalign_req_ready <= 1'b1;
                            state_q             <= S_IDLE;
                        end
                    end else if (i_ldalign_mem_ready) begin
                        o_ldalign_mem_valid <= 1'b0;
                        state_q             <= (state_q == S_REQ0) ? S_WAIT0 : S_WAIT1;
                    end
                end
                S_WAIT0, S_WAIT1: begin
                    if (i_ldalign_flush) begin
                        if (i_ldalign_mem_rvalid) begin
                            o_ldalign_req_ready <= 1'b1;
                            state_q             <= S_IDLE;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end else if (i_ldalign_mem_rvalid) begin
                        if (state_q == S_WAIT1) begin
                            beat1_q <= i_ldalign_mem_rdata;
                            state_q <= S_RESP;
                        end else begin
                            beat0_q <= i_ldalign_mem_rdata;
                            if (split_q) begin
                                o_ldalign_mem_valid <= 1'b1;
                                o_ldalign_mem_addr  <= addr1;
                                state_q             <= S_REQ1;
                            end else begin
                                state_q <= S_RESP;
                            end
                        end
                    end
                end
                S_RESP: begin
                    // First RESP cycle registers the merged result, then it is held.
                    if (i_ldalign_flush) begin
                        o_ldalign_rsp_valid <= 1'b0;
                        o_ldalign_req_ready <= 1'b1;
                        state_q             <= S_IDLE;
                    end else if (!o_ldalign_rsp_valid) begin
                        o_ldalign_rsp_valid <= 1'b1;
                        o_ldalign_rdata     <= merged;
                        o_ldalign_r_w_size  <= size_q;
                        o_ldalign_su_extend <= su_q;
                        o_ldalign_split     <= split_q;
                    end else if (i_ldalign_rsp_ready) begin
                        o_ldalign_rsp_valid <= 1'b0;
                        o_ldalign_req_ready <= 1'b1;
                        state_q             <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (i_ldalign_mem_rvalid) begin
                        o_ldalign_req_ready <= 1'b1;
                        state_q             <= S_IDLE;
                    end
                end
                default: begin
                    o_ldalign_req_ready <= 1'b1;
                    o_ldalign_mem_valid <= 1'b0;
                    o_ldalign_rsp_valid <= 1'b0;
                    state_q             <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/riscv_core_ldalign.md
Name: riscv_core_ldalign

Overview:
- Load-alignment stage directly upstream of the load sign/zero-extend stage.
- Accepts a load request (byte address, size, signed flag) and issues one aligned 64-bit data-cache read, or two if the access crosses a doubleword boundary.
- Merges the read beats and right-justifies the loaded bytes, zeroing all bytes above the access size.
- Hands data, size and signed flag to the extend stage over a valid/ready handshake.

Parameters:
- XLEN, 64, data width in bits; only 64 is supported.
- ADDR_W, 64, address width in bits.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_ldalign_req_valid  input  1  load request valid.
- o_ldalign_req_ready  output  1  request accepted when valid&&ready.
- i_ldalign_addr  input  ADDR_W  byte address.
- i_ldalign_r_w_size  input  2  access size: 00=B, 01=H, 10=W, 11=D.
- i_ldalign_su_extend  input  1  1=signed load; passed through only.
- i_ldalign_flush  input  1  abort the in-flight load.
- o_ldalign_mem_valid  output  1  cache read request valid.
- i_ldalign_mem_ready  input  1  cache accepts the read.
- o_ldalign_mem_addr  output  ADDR_W  doubleword-aligned read address; bits [2:0] always 0.
- i_ldalign_mem_rvalid  input  1  read data valid.
- i_ldalign_mem_rdata  input  XLEN  read data, little-endian.
- o_ldalign_rsp_valid  output  1  aligned result valid.
- i_ldalign_rsp_ready  input  1  extend stage consumes the result.
- o_ldalign_rdata  output  XLEN  right-justified bytes; bytes above size are zero.
- o_ldalign_r_w_size  output  2  captured size.
- o_ldalign_su_extend  output  1  captured signed flag.
- o_ldalign_split  output  1  1 when the current load used two beats.

Behaviour:
- Reset (asynchronous, i_rst=1): state=IDLE; every output 0 except o_ldalign_req_ready=1; beat buffer cleared.
- Derived values: off=addr[2:0]; nbytes=1<<size; split=(off+nbytes>8); addr0={addr[ADDR_W-1:3],3'b000}; addr1=addr0+8, modulo 2^ADDR_W (wraps at the top of the address space).
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP, DRAIN.
- IDLE:
  - req_ready=1.
  - On valid&&ready, capture addr, size, su and split; go to REQ0.
- REQ0:
  - mem_valid=1, mem_addr=addr0.
  - On mem_ready go to WAIT0.
- WAIT0:
  - On rvalid, store rdata as beat0.
  - Go to REQ1 if split, else RESP.
- REQ1:
  - mem_valid=1, mem_addr=addr1.
  - On mem_ready go to WAIT1.
- WAIT1:
  - On rvalid, store beat1; go to RESP.
- RESP:
  - rsp_valid=1; rdata, size, su and split are registered and held stable until rsp_ready.
  - On rsp_ready go to IDLE.
  - The next request can be accepted no earlier than the following cycle; there is no IDLE bypass.
- Merge rule:
  - raw = (beat0 >> 8*off) | (split ? beat1 << 8*(8-off) : 0).
  - o_ldalign_rdata = raw AND'ed with the low nbytes byte mask.
- Memory ordering:
  - At most one read is outstanding.
  - rvalid arrives at least 1 cycle after the mem_valid&&mem_ready handshake.
  - rvalid in IDLE, REQx or RESP is ignored.
  - mem_valid, once asserted, stays high with a stable address until mem_ready, unless flushed in REQx.
- Latency: with mem_ready=1 and rvalid one cycle after accept:
  - Unsplit load: rsp_valid 4 cycles after the request handshake.
  - Split load: rsp_valid 6 cycles after the request handshake.
- Flush (priority over every other transition in the same cycle):
  - In REQ0/REQ1: go to IDLE. If mem_ready is high in that same cycle, go to DRAIN instead, because the read was accepted.
  - In WAIT0/WAIT1: go to DRAIN; if rvalid is high in that same cycle, go to IDLE.
  - In RESP: drop rsp_valid; go to IDLE.
  - In IDLE or DRAIN: flush is ignored; a request presented with flush in IDLE is still accepted.
- DRAIN: req_ready=0, mem_valid=0; on rvalid, discard the data and go to IDLE.
- rsp_valid is never asserted for a flushed load.
- Reset mid-operation: immediate return to IDLE; the cache side is reset by the same i_rst, so no drain is required.

Test Plan:
- LD at 0x1000, beat 0x1122334455667788 -> one read at 0x1000; rdata=0x1122334455667788, split=0, size=11; rsp_valid 4 cycles after accept.
- LB at 0x1003, su=1, same beat -> one read; rdata=0x0000000000000055, su_extend=1.
- LW at 0x1006; beats 0x1122334455667788 @0x1000, 0x99AABBCCDDEEFFEE @0x1008 -> two reads; rdata=0x00000000FFEE1122, split=1.
- LD at 0x1001, same beats -> rdata=0xEE11223344556677; hold rsp_ready=0 for 5 cycles -> outputs stable and rsp_valid held, then one handshake.
- LH at 0xFFFF_FFFF_FFFF_FFFF (ADDR_W=64) -> reads at 0xFFFF_FFFF_FFFF_FFF8, then 0x0; address wraps.
- Flush in WAIT1 with rvalid delayed 3 cycles -> DRAIN; req_ready stays 0 until rvalid, then 1; rsp_valid never asserted. Separately, assert i_rst in WAIT0 -> all outputs 0 and req_ready=1 asynchronously.
